// File: rtl/aes_pkg.sv
// Shared AES constants: GF(2^8) multiplier select codes, the MixColumns
// state encoding, and the forward/inverse coefficient rows. Also holds the
// helpers that turn a (row, column) position into a coefficient and select.
package aes_pkg;

    // Select codes understood by the mult GF(2^8) multiplier
    localparam logic [2:0] SEL_X2  = 3'b000;
    localparam logic [2:0] SEL_X3  = 3'b001;
    localparam logic [2:0] SEL_X09 = 3'b010;
    localparam logic [2:0] SEL_X0B = 3'b011;
    localparam logic [2:0] SEL_X0D = 3'b100;
    localparam logic [2:0] SEL_X0E = 3'b101;

    // Column engine states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // First matrix row, most significant byte is column 0
    localparam logic [31:0] FWD_ROW = 32'h02_03_01_01;
    localparam logic [31:0] INV_ROW = 32'h0E_0B_0D_09;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficient for output row r, input column c: the base row rotated
    // right by r, so the entry used is base[(c - r) mod 4]
    function automatic logic [7:0] row_coef(input logic [31:0] row,
                                            input logic [1:0]  r,
                                            input logic [1:0]  c);
        logic [1:0] idx;
        logic [7:0] coef;
        idx = c - r;
        case (idx)
            2'd0:    coef = row[31:24];
            2'd1:    coef = row[23:16];
            2'd2:    coef = row[15:8];
            default: coef = row[7:0];
        endcase
        return coef;
    endfunction

    // Map a coefficient byte to a multiplier select (01 is bypassed outside)
    function automatic logic [2:0] coef_sel(input logic [7:0] coef);
        logic [2:0] sel;
        case (coef)
            8'h03:   sel = SEL_X3;
            8'h09:   sel = SEL_X09;
            8'h0B:   sel = SEL_X0B;
            8'h0D:   sel = SEL_X0D;
            8'h0E:   sel = SEL_X0E;
            default: sel = SEL_X2;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mult.sv
// GF(2^8) constant multiplier (polynomial 0x11B) for the MixColumns
// coefficient set. The select picks which constant multiplies the byte.
module mult
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [2:0] sel,
    output logic [7:0] p
);

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    assign x2 = xtime(a);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    // Combine the power-of-two multiples for the selected constant
    always_comb begin
        p = x2;
        case (sel)
            SEL_X2:  p = x2;
            SEL_X3:  p = x2 ^ a;
            SEL_X09: p = x8 ^ a;
            SEL_X0B: p = x8 ^ x2 ^ a;
            SEL_X0D: p = x8 ^ x4 ^ a;
            SEL_X0E: p = x8 ^ x4 ^ x2;
            default: p = x2;
        endcase
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one output byte per cycle, four cycles
// per column, with a valid/ready handshake on both sides.
// Optional feature: define MIX_COLUMNS_INV_EN to enable inverse mode; without
// it the inv input is ignored and only forward coefficients reach the
// multipliers, so the inverse paths are constant-folded away.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int ROWS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] col_out
);

    logic [1:0]  state_reg;
    logic [1:0]  r_reg;
    logic [31:0] a_reg;
    logic [31:0] col_out_reg;
    logic        inv_reg;
    logic [31:0] row_base;
    logic [7:0]  term [4];
    logic [7:0]  b_next;

`ifdef MIX_COLUMNS_INV_EN
    // Capture the mode together with the operand on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_reg <= 1'b0;
        else if (state_reg == ST_IDLE && in_valid)
            inv_reg <= inv;
    end
    assign row_base = inv_reg ? INV_ROW : FWD_ROW;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign inv_reg    = 1'b0;
    assign row_base   = FWD_ROW;
`endif

    // One multiplier per input byte; coefficient 01 bypasses its multiplier
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] coef;
            logic [7:0] prod;
            logic [7:0] a_byte;

            assign a_byte = a_reg[31 - 8*gi -: 8];
            assign coef   = row_coef(row_base, r_reg, 2'(gi));

            mult u_mult (
                .a   (a_byte),
                .sel (coef_sel(coef)),
                .p   (prod)
            );

            assign term[gi] = (coef == 8'h01) ? a_byte : prod;
        end
    endgenerate

    assign b_next = term[0] ^ term[1] ^ term[2] ^ term[3];

    // Handshake FSM: accept in IDLE, produce one byte per CALC cycle,
    // hold the result in DONE until the downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            r_reg       <= 2'd0;
            a_reg       <= 32'd0;
            col_out_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= col_in;
                        r_reg     <= 2'd0;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    case (r_reg)
                        2'd0:    col_out_reg[31:24] <= b_next;
                        2'd1:    col_out_reg[23:16] <= b_next;
                        2'd2:    col_out_reg[15:8]  <= b_next;
                        default: col_out_reg[7:0]   <= b_next;
                    endcase
                    r_reg <= r_reg + 2'd1;
                    if (r_reg == 2'(ROWS - 1))
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign col_out   = col_out_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: known-answer columns, random
// columns against a matrix-product reference model, backpressure, reset in
// the middle of a column, and back-to-back throughput.
module tb_mix_columns_seq;

`ifdef MIX_COLUMNS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] col_in;
    logic        inv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] col_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mix_columns_seq #(.ROWS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .col_in    (col_in),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .col_out   (col_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain shift-and-add GF(2^8) product, polynomial 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
        end
        return p;
    endfunction

    // Circulant matrix times column
    function automatic logic [31:0] ref_col(input logic [31:0] col, input bit iv);
        logic [7:0]  fwd [4];
        logic [7:0]  inr [4];
        logic [7:0]  a   [4];
        logic [7:0]  b;
        logic [31:0] res;
        fwd = '{8'h02, 8'h03, 8'h01, 8'h01};
        inr = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        for (int c = 0; c < 4; c++) a[c] = 8'((col >> (24 - 8*c)) & 32'hFF);
        res = 32'd0;
        for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int c = 0; c < 4; c++)
                b = b ^ gmul(iv ? inr[(c - r + 4) % 4] : fwd[(c - r + 4) % 4], a[c]);
            res = (res << 8) | 32'(b);
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Count posedges from the accept edge until out_valid is seen
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One column through the block with an optional output stall
    task automatic do_col(input logic [31:0] col, input bit iv,
                          input logic [31:0] exp, input int stall);
        int n;
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        col_in    = col;
        inv       = iv;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        col_in   = $urandom;
        inv      = 1'($urandom);
        wait_out(lat);
        chk("latency", 32'(lat), 32'd4);
        chk("col_out", col_out, exp);
        $display("txn col_in=%h inv=%0d col_out=%h expected=%h latency=%0d stall=%0d",
                 col, iv, col_out, exp, lat, stall);
        for (int i = 0; i < stall; i++) begin
            col_in   = $urandom;
            in_valid = 1'($urandom);
            inv      = 1'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", col_out, exp);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] col;
        bit          iv;
        int          acc;
        int          prev;
        int          lat;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        col_in    = 32'd0;
        inv       = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_col_out", col_out, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Known-answer columns
        do_col(32'hDB135345, 1'b0, 32'h8E4DA1BC, 0);
        do_col(32'hF20A225C, 1'b0, 32'h9FDC589D, 0);
        do_col(32'hC6C6C6C6, 1'b0, 32'hC6C6C6C6, 0);
`ifdef MIX_COLUMNS_INV_EN
        do_col(32'h8E4DA1BC, 1'b1, 32'hDB135345, 0);
        do_col(32'h9FDC589D, 1'b1, 32'hF20A225C, 0);
`else
        // inv must be ignored: forward result expected
        do_col(32'hDB135345, 1'b1, 32'h8E4DA1BC, 0);
`endif

        // Backpressure with toggling inputs
        do_col(32'hDB135345, 1'b0, 32'h8E4DA1BC, 10);

        // Reset while r=2 in CALC discards the column
        @(negedge clk);
        in_valid = 1'b1;
        col_in   = 32'hF20A225C;
        inv      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_col_out", col_out, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        do_col(32'hDB135345, 1'b0, 32'h8E4DA1BC, 0);

        // Back-to-back: one accept every 6 cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            col = $urandom;
            iv  = 1'($urandom);
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            col_in = col;
            inv    = iv;
            @(posedge clk);
            #1;
            acc = cyc;
            if (k > 0) chk("b2b_interval", 32'(acc - prev), 32'd6);
            prev = acc;
            wait_out(lat);
            chk("b2b_latency", 32'(lat), 32'd4);
            chk("b2b_col_out", col_out, ref_col(col, iv & INV_EN));
            $display("txn b2b col_in=%h inv=%0d col_out=%h cycle=%0d", col, iv, col_out, acc);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (8) @(negedge clk);

        // Random columns and modes against the reference model
        for (int k = 0; k < 20; k++) begin
            col = $urandom;
            iv  = 1'($urandom);
            do_col(col, iv, ref_col(col, iv & INV_EN), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
